// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control bundle layout, widths and the NOP control word.
package mips_pipe_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned CTRL_W     = 10;
  localparam int unsigned PERF_CNT_W = 32;

  // Control bundle bit positions, MSB first: regwrite .. regdst, then aluop[3:0]
  localparam int unsigned CTRL_REGWRITE  = 9;
  localparam int unsigned CTRL_MEMREAD   = 8;
  localparam int unsigned CTRL_MEMWRITE  = 7;
  localparam int unsigned CTRL_MEMTOREG  = 6;
  localparam int unsigned CTRL_ALUSRC    = 5;
  localparam int unsigned CTRL_REGDST    = 4;
  localparam int unsigned CTRL_ALUOP_LSB = 0;
  localparam int unsigned CTRL_ALUOP_W   = 4;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination feeds the ID instruction.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use_c
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt & (ex_rt == id_rt);

  // $0 is hard-wired, so a load targeting it never creates a dependency
  assign load_use_c = ex_valid & ex_memread & (ex_rt != '0) & (rs_match | rt_match) & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and hold handling.
// Optional ID_EX_PERF_CNT_EN adds saturating bubble/hold cycle counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = mips_pipe_pkg::CTRL_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             id_valid_i,
  input  logic [mips_pipe_pkg::REG_W-1:0]  id_rs_i,
  input  logic [mips_pipe_pkg::REG_W-1:0]  id_rt_i,
  input  logic [mips_pipe_pkg::REG_W-1:0]  id_rd_i,
  input  logic                             id_uses_rt_i,
  input  logic [DATA_W-1:0]                id_rs_data_i,
  input  logic [DATA_W-1:0]                id_rt_data_i,
  input  logic [DATA_W-1:0]                id_imm_i,
  input  logic [CTRL_W-1:0]                id_ctrl_i,
  input  logic                             flush_i,
  input  logic                             hold_i,
  output logic                             ex_valid_o,
  output logic [mips_pipe_pkg::REG_W-1:0]  ex_rs_o,
  output logic [mips_pipe_pkg::REG_W-1:0]  ex_rt_o,
  output logic [mips_pipe_pkg::REG_W-1:0]  ex_rd_o,
  output logic [DATA_W-1:0]                ex_rs_data_o,
  output logic [DATA_W-1:0]                ex_rt_data_o,
  output logic [DATA_W-1:0]                ex_imm_o,
  output logic [CTRL_W-1:0]                ex_ctrl_o,
  output logic                             stall_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [mips_pipe_pkg::PERF_CNT_W-1:0] bubble_cnt_o,
  output logic [mips_pipe_pkg::PERF_CNT_W-1:0] hold_cnt_o
`endif
);

  logic load_use;
  logic clear;
  logic capture;

  load_use_detect u_load_use_detect (
    .ex_valid   (ex_valid_o),
    .ex_memread (ex_ctrl_o[mips_pipe_pkg::CTRL_MEMREAD]),
    .ex_rt      (ex_rt_o),
    .id_valid   (id_valid_i),
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .id_uses_rt (id_uses_rt_i),
    .load_use_c (load_use)
  );

  // Priority rst > flush > hold > load-use > load collapses to clear/capture
  assign clear   = rst_i | flush_i | (~hold_i & load_use);
  assign capture = ~hold_i;
  assign stall_o = ~rst_i & (hold_i | (load_use & ~flush_i));

  always_ff @(posedge clk_i) begin
    if (clear) begin
      ex_valid_o   <= 1'b0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_ctrl_o    <= CTRL_W'(mips_pipe_pkg::CTRL_NOP);
    end else if (capture) begin
      ex_valid_o   <= id_valid_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_ctrl_o    <= id_valid_i ? id_ctrl_i : CTRL_W'(mips_pipe_pkg::CTRL_NOP);
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_evt;
  logic hold_evt;

  assign bubble_evt = ~flush_i & ~hold_i & load_use;
  assign hold_evt   = ~flush_i & hold_i;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
      hold_cnt_o   <= '0;
    end else begin
      if (bubble_evt && (bubble_cnt_o != '1)) begin
        bubble_cnt_o <= bubble_cnt_o + mips_pipe_pkg::PERF_CNT_W'(1);
      end
      if (hold_evt && (hold_cnt_o != '1)) begin
        hold_cnt_o <= hold_cnt_o + mips_pipe_pkg::PERF_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios followed by random traffic.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 10;
  localparam logic [9:0] C_LW   = 10'h360;
  localparam logic [9:0] C_ADD  = 10'h212;
  localparam logic [9:0] C_ADDI = 10'h220;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i = 1'b1;
  logic              id_valid_i = 1'b0;
  logic [4:0]        id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
  logic              id_uses_rt_i = 1'b0;
  logic [DATA_W-1:0] id_rs_data_i = '0, id_rt_data_i = '0, id_imm_i = '0;
  logic [CTRL_W-1:0] id_ctrl_i = '0;
  logic              flush_i = 1'b0, hold_i = 1'b0;
  logic              ex_valid_o;
  logic [4:0]        ex_rs_o, ex_rt_o, ex_rd_o;
  logic [DATA_W-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              stall_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       bubble_cnt_o, hold_cnt_o;
`endif

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_uses_rt_i(id_uses_rt_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_ctrl_i(id_ctrl_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid_o(ex_valid_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_ctrl_o(ex_ctrl_o), .stall_o(stall_o)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o)
`endif
  );

  typedef struct packed {
    logic rst, flush, hold, valid;
    logic [4:0] rs, rt, rd;
    logic uses_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic [9:0] ctrl;
  } stim_t;

  typedef struct packed {
    logic valid;
    logic [4:0] rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [9:0] ctrl;
  } ex_t;

  typedef struct packed {
    logic stall;
    ex_t ex;
    logic [31:0] bcnt, hcnt;
  } exp_t;

  exp_t sb[$];
  ex_t m = '0;
  logic [31:0] m_bcnt = '0, m_hcnt = '0;
  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endfunction

  function automatic stim_t mk(input logic rst, input logic flush, input logic hold, input logic valid,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic uses_rt, input logic [9:0] ctrl);
    stim_t s;
    s.rst = rst; s.flush = flush; s.hold = hold; s.valid = valid;
    s.rs = rs; s.rt = rt; s.rd = rd; s.uses_rt = uses_rt; s.ctrl = ctrl;
    s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
    return s;
  endfunction

  // Drive one cycle of ID inputs and queue the expected stall and resulting EX contents
  task automatic step(input stim_t s);
    exp_t e;
    logic haz;
    @(negedge clk);
    rst_i = s.rst; flush_i = s.flush; hold_i = s.hold; id_valid_i = s.valid;
    id_rs_i = s.rs; id_rt_i = s.rt; id_rd_i = s.rd; id_uses_rt_i = s.uses_rt;
    id_rs_data_i = s.rs_data; id_rt_data_i = s.rt_data; id_imm_i = s.imm; id_ctrl_i = s.ctrl;
    haz = m.valid && m.ctrl[8] && (m.rt != 5'd0) &&
          ((m.rt == s.rs) || (s.uses_rt && (m.rt == s.rt))) && s.valid;
    if (s.rst) begin
      e.stall = 1'b0; m = '0; m_bcnt = '0; m_hcnt = '0;
    end else if (s.flush) begin
      e.stall = s.hold; m = '0;
    end else if (s.hold) begin
      e.stall = 1'b1;
      if (m_hcnt != 32'hFFFF_FFFF) m_hcnt = m_hcnt + 1;
    end else if (haz) begin
      e.stall = 1'b1; m = '0;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
    end else begin
      e.stall = 1'b0;
      m.valid = s.valid; m.rs = s.rs; m.rt = s.rt; m.rd = s.rd;
      m.rs_data = s.rs_data; m.rt_data = s.rt_data; m.imm = s.imm;
      m.ctrl = s.valid ? s.ctrl : 10'd0;
    end
    e.ex = m; e.bcnt = m_bcnt; e.hcnt = m_hcnt;
    sb.push_back(e);
  endtask

  // Monitor: stall mid-cycle, EX registers just after the following edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_o", 64'(stall_o), 64'(e.stall));
        @(posedge clk);
        #1;
        chk("ex_valid_o", 64'(ex_valid_o), 64'(e.ex.valid));
        chk("ex_rs_o", 64'(ex_rs_o), 64'(e.ex.rs));
        chk("ex_rt_o", 64'(ex_rt_o), 64'(e.ex.rt));
        chk("ex_rd_o", 64'(ex_rd_o), 64'(e.ex.rd));
        chk("ex_rs_data_o", 64'(ex_rs_data_o), 64'(e.ex.rs_data));
        chk("ex_rt_data_o", 64'(ex_rt_data_o), 64'(e.ex.rt_data));
        chk("ex_imm_o", 64'(ex_imm_o), 64'(e.ex.imm));
        chk("ex_ctrl_o", 64'(ex_ctrl_o), 64'(e.ex.ctrl));
        if (!ex_valid_o)
          chk("bubble_side_effects", 64'({ex_ctrl_o[9], ex_ctrl_o[8], ex_ctrl_o[7]}), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt_o", 64'(bubble_cnt_o), 64'(e.bcnt));
        chk("hold_cnt_o", 64'(hold_cnt_o), 64'(e.hcnt));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  stim_t idle;
  stim_t add_dep;

  initial begin
    idle = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 10'd0);
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 10'd0));
    step(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd8, 5'd0, 1'b0, C_LW));

    // Independent add follows a load with no stall
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_LW));
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 5'd11, 5'd9, 1'b1, C_ADD));
    step(idle);

    // Dependent add: one bubble, then re-presented add enters EX
    add_dep = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd2, 5'd9, 1'b1, C_ADD);
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_LW));
    step(add_dep);
    step(add_dep);
    step(idle);

    // rt matches but is not read; load into $0
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_LW));
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd8, 5'd0, 1'b0, C_ADDI));
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, C_LW));
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, C_ADD));

    // Flush overrides the load-use stall
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_LW));
    step(mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 5'd2, 5'd9, 1'b1, C_ADD));

    // Three-cycle hold from a fresh reset
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 10'd0));
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_LW));
    for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 5'd11, 5'd9, 1'b1, C_ADD));
    step(idle);

    // Reset arriving during a load-use stall
    add_dep = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd2, 5'd9, 1'b1, C_ADD);
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0, 1'b0, C_LW));
    step(add_dep);
    add_dep.rst = 1'b1;
    step(add_dep);
    add_dep.rst = 1'b0;
    step(add_dep);

    for (int i = 0; i < 600; i++) begin
      stim_t s;
      logic [9:0] c;
      c = 10'($urandom);
      c[8] = 1'($urandom_range(0, 1));
      s = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), c);
      step(s);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/immediate width.
REQ-002 Parameter CTRL_W, default 10, packed control bundle width (regwrite, memread, memwrite, memtoreg, alusrc, regdst, aluop[3:0]).
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 id_valid_i  in  1  ID holds a real instruction.
REQ-006 id_rs_i, id_rt_i, id_rd_i  in  5 each  ID register specifiers.
REQ-007 id_uses_rt_i  in  1  ID instruction reads rt as a source.
REQ-008 id_rs_data_i, id_rt_data_i, id_imm_i  in  DATA_W each  register-file reads, sign-extended immediate.
REQ-009 id_ctrl_i  in  CTRL_W  decoded control bundle.
REQ-010 flush_i  in  1  taken branch/jump resolved downstream; squash ID instruction.
REQ-011 hold_i  in  1  downstream busy; freeze stage.
REQ-012 ex_valid_o  out  1; ex_rs_o, ex_rt_o, ex_rd_o  out  5; ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W; ex_ctrl_o  out  CTRL_W  registered EX-stage copies; ex_rs_o/ex_rt_o feed the forwarding unit.
REQ-013 stall_o  out  1  combinational; freezes PC and IF/ID.

Function
REQ-014 Load-use hazard = ex_valid_o & ex_ctrl_o.memread & ex_rt_o!=0 & (ex_rt_o==id_rs_i | (id_uses_rt_i & ex_rt_o==id_rt_i)) & id_valid_i.
REQ-015 Priority per edge: rst_i > flush_i > hold_i > load-use > load.
REQ-016 flush_i: next state is bubble (valid 0, ctrl 0, specifiers 0, data 0), even if hold_i is high.
REQ-017 hold_i without flush: all registers keep value.
REQ-018 Load-use without flush/hold: insert bubble; ID instruction re-presented next cycle.
REQ-019 Otherwise: capture all id_* inputs; ex_valid_o <= id_valid_i; ctrl forced to 0 when id_valid_i is 0.
REQ-020 stall_o = hold_i | (load-use & ~flush_i); stall_o is 0 during rst_i.
REQ-021 Latency ID->EX exactly one cycle absent stall; load-use costs exactly one bubble; back-to-back loads each produce at most one bubble.
REQ-022 Bubble never writes state downstream: ex_ctrl_o regwrite/memwrite/memread all 0 whenever ex_valid_o is 0.

Reset
REQ-023 rst_i high at an edge: every output register 0, counters 0; stall_o 0 while rst_i high.
REQ-024 Reset mid-stall or mid-hold discards the held instruction; first post-reset edge loads normally.

Configuration
REQ-025 Macro ID_EX_PERF_CNT_EN defined: add outputs bubble_cnt_o and hold_cnt_o (32 each), counting load-use bubble cycles and hold cycles, saturating at all-ones, cleared by reset.
REQ-026 Macro undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-027 Shared package mips_pipe_pkg holds CTRL_W, control bit-position constants, and the all-zero NOP control constant.
REQ-028 Load-use compare lives in sub-module load_use_detect (combinational); register and priority logic in id_ex_stage.

Verification
REQ-029 Plain flow: lw $8 ID then add $9,$10,$11 -> add reaches EX next cycle, stall_o 0 throughout, ex_rs_o=10.
REQ-030 Load-use: lw $8 in EX, ID add $9,$8,$2 -> stall_o 1 one cycle, ex_valid_o 0 next cycle, add enters EX the following cycle.
REQ-031 rt-use gating: lw $8 in EX, ID addi $8,$3 (id_uses_rt_i 0, rt=8) -> no stall; lw $0 in EX -> no stall.
REQ-032 Flush over load-use: load-use condition plus flush_i=1 -> stall_o 0, bubble loaded.
REQ-033 Hold: hold_i 1 for 3 cycles with valid EX instruction -> outputs unchanged 3 cycles, stall_o 1; with ID_EX_PERF_CNT_EN hold_cnt_o=3.
REQ-034 Reset during load-use stall -> next cycle ex_valid_o 0, ex_ctrl_o 0, stall_o 0.
